// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage widths, reset PC and FSM state encoding
package fetch_unit_pkg;

    localparam int              FETCH_PC_W     = 16;
    localparam int              FETCH_INSTR_W  = 32;
    localparam logic [15:0]     FETCH_RESET_PC = 16'h0000;
    localparam int              FETCH_DEPTH    = 2;

    // IDLE: nothing outstanding; BUSY: outstanding, word kept;
    // DISCARD: outstanding, word dropped because a redirect overtook it.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        DISCARD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small shift FIFO of {pc, instr} with a registered head
module fetch_queue #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [INSTR_W-1:0]         push_instr,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [PC_W-1:0]            head_pc,
    output logic [INSTR_W-1:0]         head_instr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               pop_ok;
    logic [CW-1:0]      wr_idx;

    // Entry 0 is always the head, so the head outputs come straight from flops.
    assign head_valid = (count != '0);
    assign pop_ok     = pop && head_valid;
    assign wr_idx     = count - CW'(pop_ok);
    assign head_pc    = pc_mem[0];
    assign head_instr = instr_mem[0];

    // Storage and occupancy: pop shifts toward the head, push lands after the survivors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_mem[i]    <= pc_mem[i+1];
                    instr_mem[i] <= instr_mem[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        pc_mem[i]    <= push_pc;
                        instr_mem[i] <= push_instr;
                    end
                end
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // The fetch credit scheme must never let a push arrive at a full queue.
    always @(posedge clk) begin
        assert (rst || flush || !push || pop_ok || count != CW'(DEPTH));
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, memory req/ack FSM, credit, prefetch queue
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INSTR_W  = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC),
    parameter int              DEPTH    = FETCH_DEPTH
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n, addr_n;
    logic            req_n;
    logic            ack_ok, push, pop, credit, issue_ok;
    logic [CW-1:0]   count, count_next;

    // An ack only counts while a request is actually outstanding.
    assign ack_ok     = imem_ack && imem_req;
    // A redirect overrides everything queue-side: no push, no pop, flush.
    assign push       = ack_ok && (state == BUSY) && !redirect;
    assign pop        = instr_valid && instr_ready && !redirect;
    assign count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));
    // A new request is only issued when nothing will remain outstanding after
    // this cycle, so the credit test reduces to room for one more word.
    assign credit     = (count_next < CW'(DEPTH));
    assign issue_ok   = !halt && !redirect && credit;

    // State, request and PC registers.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            fetch_pc  <= fetch_pc_n;
        end
    end

    // Next-state: issue, complete, or discard the outstanding request.
    always_comb begin
        state_n    = state;
        req_n      = imem_req;
        addr_n     = imem_addr;
        fetch_pc_n = fetch_pc;
        if (redirect) begin
            fetch_pc_n = redirect_pc;
        end
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    state_n    = BUSY;
                    req_n      = 1'b1;
                    addr_n     = fetch_pc;
                    fetch_pc_n = fetch_pc + PC_W'(1);
                end
            end
            BUSY, DISCARD: begin
                if (ack_ok) begin
                    if (issue_ok) begin
                        state_n    = BUSY;
                        addr_n     = fetch_pc;
                        fetch_pc_n = fetch_pc + PC_W'(1);
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end else if (redirect) begin
                    state_n = DISCARD;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    fetch_queue #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst_f),
        .push       (push),
        .push_pc    (imem_addr),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid, instr_ready, redirect, halt;
    logic [31:0] instr;
    logic [15:0] instr_pc, redirect_pc;

    logic        w_req, w_ack, w_valid;
    logic [15:0] w_addr, w_pc;
    logic [31:0] w_rdata, w_instr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_f(rst_f), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .instr_valid(w_valid),
        .instr(w_instr), .instr_pc(w_pc), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0)
    );

    function automatic logic [31:0] mk(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: ack in the mem_lat-th cycle of each request.
    int mem_lat  = 1;
    int wait_cnt = 0;
    bit spur     = 0;
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst_f) begin
                wait_cnt = 0;
            end else if (spur) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end else if (imem_req) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mk(imem_addr);
                    wait_cnt   = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Second memory: zero-wait acks for the wrap instance.
    initial begin
        w_ack   = 1'b0;
        w_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            w_ack   = !rst_f && w_req;
            w_rdata = mk(w_addr);
        end
    end

    // Scoreboard: expected words are queued when a kept ack is driven and
    // compared when the consumer takes the head.
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] next_addr = 16'h0000;
    bit          discard   = 0;
    int          kept_acks = 0;
    bit          prev_req  = 0;
    bit          prev_ack  = 0;
    logic [15:0] w_alog[$];
    logic [15:0] w_plog[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst_f) begin
            exp_q.delete();
            next_addr = 16'h0000;
            discard   = 0;
            prev_req  = 0;
            prev_ack  = 0;
            w_alog.delete();
            w_plog.delete();
        end else begin
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_delivery_pc", {48'h0, instr_pc}, 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", {48'h0, instr_pc}, {48'h0, e.pc});
                    check("deliver_instr", {32'h0, instr}, {32'h0, e.instr});
                end
            end
            if (imem_ack && imem_req) begin
                if (redirect || discard) begin
                    discard = 0;
                end else begin
                    check("fetch_addr", {48'h0, imem_addr}, {48'h0, next_addr});
                    exp_q.push_back('{pc: next_addr, instr: mk(next_addr)});
                    next_addr = next_addr + 16'h1;
                    kept_acks++;
                end
            end
            if (redirect) begin
                if (imem_req && !imem_ack) discard = 1;
                exp_q.delete();
                next_addr = redirect_pc;
            end
            prev_req = imem_req;
            prev_ack = imem_ack;
            if (w_ack && w_req) w_alog.push_back(w_addr);
            if (w_valid) w_plog.push_back(w_pc);
        end
    end

    // Returns at posedge+2 of the first cycle of a new request.
    task automatic wait_new_req(input string name);
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk);
            #2;
            if (imem_req && (!prev_req || prev_ack)) ok = 1;
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (instr_valid) ok = 1;
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    typedef struct {
        logic        ready;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    vec_t        tbl[9];
    logic [15:0] wrap_exp[4];
    logic [15:0] a_pc;
    int          k0, rc;
    bit          seen, ok;
    logic [15:0] got;

    initial begin
        // ready drives the next edge; the other fields are expected after this edge.
        tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0001, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 16'h0001, 1'b1, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0001};
        tbl[5] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h0001};
        tbl[6] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002};
        tbl[7] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0003};
        tbl[8] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'h0004};
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;

        rst_f       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {63'h0, imem_req}, 64'd0);
        check("rst_addr", {48'h0, imem_addr}, 64'h0000);
        check("rst_valid", {63'h0, instr_valid}, 64'd0);
        check("rst_instr", {32'h0, instr}, 64'd0);
        check("rst_instr_pc", {48'h0, instr_pc}, 64'd0);
        check("rst_wrap_addr", {48'h0, w_addr}, 64'hFFFE);
        #1;
        rst_f = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {30'h0, imem_req, imem_addr, instr_valid, instr_pc},
                  {30'h0, tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc});
            #1;
            instr_ready = tbl[i].ready;
        end

        k0 = kept_acks;
        repeat (8) @(posedge clk);
        check("back_to_back_acks", 64'(kept_acks - k0), 64'd8);

        for (int i = 0; i < 4; i++) begin
            if (w_alog.size() > i && w_plog.size() > i) begin
                check($sformatf("wrap_addr%0d", i), {48'h0, w_alog[i]}, {48'h0, wrap_exp[i]});
                check($sformatf("wrap_pc%0d", i), {48'h0, w_plog[i]}, {48'h0, wrap_exp[i]});
            end else begin
                check($sformatf("wrap_missing%0d", i), 64'd0, 64'd1);
            end
        end

        // Redirect in the same cycle as an ack and a pop.
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            #2;
            if (imem_ack && instr_valid) ok = 1;
            else @(posedge clk);
        end
        check("redir_ack_setup", {63'h0, ok}, 64'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        @(posedge clk);
        #1;
        check("redir_ack_flush", {63'h0, instr_valid}, 64'd0);
        check("redir_ack_idle", {63'h0, imem_req}, 64'd0);
        #1;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check("redir_ack_restart", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0100});
        wait_valid("redir_ack");
        check("redir_ack_first_pc", {48'h0, instr_pc}, 64'h0100);

        // halt with a request outstanding.
        mem_lat = 3;
        wait_new_req("halt_req");
        a_pc = imem_addr;
        halt = 1'b1;
        rc   = 0;
        seen = 0;
        got  = '0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (imem_req) rc++;
            if (instr_valid && !seen) begin
                seen = 1;
                got  = instr_pc;
            end
        end
        check("halt_req_cycles", 64'(rc), 64'd2);
        check("halt_delivered", {47'h0, seen, got}, {47'h0, 1'b1, a_pc});
        #1;
        halt = 1'b0;
        wait_new_req("halt_resume");
        check("halt_resume_addr", {48'h0, imem_addr}, {48'h0, a_pc + 16'h1});

        // Redirect during the second wait cycle of a 3-cycle access.
        wait_new_req("discard_req");
        a_pc = imem_addr;
        @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(posedge clk);
        #1;
        check("discard_flush", {63'h0, instr_valid}, 64'd0);
        check("discard_hold", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, a_pc});
        #1;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check("discard_restart", {46'h0, imem_req, imem_addr, instr_valid},
              {46'h0, 1'b1, 16'h0040, 1'b0});
        wait_valid("discard");
        check("discard_first_pc", {48'h0, instr_pc}, 64'h0040);

        // Reset mid-request, then a stray ack with no request outstanding.
        wait_new_req("rst_mid");
        rst_f = 1'b1;
        #1;
        check("rst_mid", {46'h0, imem_req, imem_addr, instr_valid}, 64'd0);
        halt = 1'b1;
        @(posedge clk);
        #2;
        rst_f = 1'b0;
        spur  = 1;
        @(posedge clk);
        #2;
        spur = 0;
        rc   = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (imem_req || instr_valid) rc++;
        end
        check("stray_ack_ignored", 64'(rc), 64'd0);
        halt = 1'b0;
        wait_new_req("post_rst");
        check("post_rst_addr", {48'h0, imem_addr}, 64'h0000);
        wait_valid("post_rst");
        check("post_rst_pc", {48'h0, instr_pc}, 64'h0000);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage, directly upstream of the SISC control unit and datapath. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a 2-entry prefetch queue and presented to the decode/control stage on a valid/ready interface. A branch redirect flushes the queue and restarts fetch at the branch target.

Parameters:
PC_W, 16, fetch/instruction address width (word-addressed, +1 per instruction)
INSTR_W, 32, instruction word width
RESET_PC, 16'h0000, first fetch address after reset
DEPTH, 2, prefetch queue entries (only 2 is required to be supported)

Ports:
clk  in  1  system clock, all state on rising edge
rst_f  in  1  asynchronous reset, active-high (1 = reset asserted)
imem_req  out  1  memory read request, registered
imem_addr  out  PC_W  read address, registered, stable while imem_req=1 until ack
imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle, request complete
imem_rdata  in  INSTR_W  instruction word, sampled only when imem_ack=1
instr_valid  out  1  queue head valid
instr  out  INSTR_W  queue head instruction
instr_pc  out  PC_W  PC of queue head
instr_ready  in  1  consumer accepts head this cycle (pop when valid&ready)
redirect  in  1  one-cycle branch redirect pulse
redirect_pc  in  PC_W  branch target, sampled when redirect=1
halt  in  1  level; while 1, no new requests are issued

Behaviour:
- Reset (async assert): state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, queue count=0, instr_valid=0, instr=0, instr_pc=0.
- Memory protocol: at most one outstanding request. imem_req and imem_addr are held until the cycle imem_ack=1. An ack with imem_req=0 is ignored. Memory latency is arbitrary (at least 1 cycle).
- Credit: a new request may be issued only when count_next + outstanding < DEPTH, where count_next = count + push - pop.
- FSM states:
  - IDLE (nothing outstanding).
  - BUSY (outstanding, result kept).
  - DISCARD (outstanding, result dropped).
- IDLE -> BUSY when !halt, !redirect and credit is available. Set imem_addr<=fetch_pc and fetch_pc<=fetch_pc+1.
- BUSY on ack:
  - Push {fetch address, imem_rdata}.
  - If !halt, !redirect and credit remains: stay BUSY with the next address (back-to-back, no bubble).
  - Else -> IDLE.
- BUSY without ack:
  - redirect -> DISCARD.
  - Otherwise hold.
- DISCARD on ack: drop the data, no push. Then, if !halt and !redirect, issue a request for fetch_pc (-> BUSY); else -> IDLE.
- Redirect (any state):
  - Flush the queue (count=0, instr_valid=0 next cycle).
  - fetch_pc<=redirect_pc.
  - A pop in the same cycle is ignored.
  - An ack in the same cycle is dropped.
  - An outstanding request with no ack this cycle -> DISCARD.
  - The request for redirect_pc issues no earlier than the cycle after redirect.
- Redirect while in DISCARD: fetch_pc is updated, the state stays DISCARD.
- Queue:
  - Push and pop in the same cycle are both honoured.
  - The head is registered, so instr_valid rises the cycle after the ack cycle.
  - Overflow is impossible by construction (credit check); push at count=DEPTH is an assertion failure.
- halt: the outstanding request still completes and pushes. The queue still drains.
- fetch_pc wraps 16'hFFFF -> 16'h0000 with no flag.
- Reset asserted mid-request: all state cleared immediately. A late ack after reset release with imem_req=0 is ignored.

Decomposition:
- Shared SISC defines header holds PC_W, INSTR_W, RESET_PC and the fetch FSM state encodings (IDLE=2'b00, BUSY=2'b01, DISCARD=2'b10).
- One sub-module: fetch_queue, a DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count, head outputs and async active-high reset.
- FSM, credit logic and PC live in fetch_unit.

Test Plan:
- Reset release, 1-cycle-latency memory, instr_ready=1 -> requests at addrs 0,1,2,… back-to-back; instr_valid one cycle after each ack; instr_pc matches 0,1,2.
- instr_ready=0 -> exactly 2 pushes (pc 0,1), then imem_req stays 0. Raising instr_ready pops pc 0 and the next request issues for addr 2.
- Memory latency 3 cycles, redirect to 16'h0040 in the second wait cycle -> ack data dropped (DISCARD), queue empty. The next request is addr 0040 and the first delivered instr_pc=0040.
- Redirect in the same cycle as ack and pop with a 2-entry queue -> no push, no pop. instr_valid=0 the next cycle, then fetch resumes at the target.
- RESET_PC=16'hFFFE, free-running -> addresses FFFE, FFFF, 0000, 0001.
- halt asserted with a request outstanding -> that word is delivered and no further imem_req. Deassert halt -> fetch continues at the next sequential PC.
